// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready handshake for uart_tx_fifo.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              tx_ena;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;

   modport master (output tx_ena, output tx_data, input tx_ready);
   modport slave  (input tx_ena, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: small input FIFO, per-bit clock divider, optional parity,
// one or two stop bits. Frames are sent back to back while the FIFO holds words.
module uart_tx_fifo #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 bus,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t              state, state_d;
   logic [DIV_W-1:0]    div_cnt, div_cnt_d;
   logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
   logic [DATA_W-1:0]   shreg, shreg_d;
   logic                par_bit, par_bit_d;
   logic                tx_d;
   logic                pop;
   logic                push;
   logic                div_last;

   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count_d;
   logic [DATA_W-1:0]   head;
   logic                fifo_nonempty;
   logic                odd_sel;

   assign push          = bus.tx_ena && bus.tx_ready;
   assign head          = mem[rd_ptr];
   assign fifo_nonempty = (fifo_count != '0);
   assign div_last      = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));
   assign odd_sel       = (PARITY == 2) ? 1'b1 : 1'b0;
   assign count_d       = fifo_count + CNT_W'(push) - CNT_W'(pop);

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.tx_data;
      end
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         bus.tx_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count   <= count_d;
         bus.tx_ready <= (count_d != CNT_W'(FIFO_DEPTH));
      end
   end

   // FSM state, counters, shifter and registered line outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= state_d;
         div_cnt <= div_cnt_d;
         bit_cnt <= bit_cnt_d;
         shreg   <= shreg_d;
         par_bit <= par_bit_d;
         tx      <= tx_d;
         tx_busy <= (state_d != IDLE);
      end
   end

   // Next-state logic; tx_d is the level the line takes after this edge
   always_comb begin
      state_d   = state;
      div_cnt_d = div_cnt;
      bit_cnt_d = bit_cnt;
      shreg_d   = shreg;
      par_bit_d = par_bit;
      tx_d      = tx;
      pop       = 1'b0;

      if (state != IDLE) begin
         div_cnt_d = div_last ? '0 : div_cnt + DIV_W'(1);
      end

      case (state)
         IDLE: begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            if (fifo_nonempty) begin
               pop       = 1'b1;
               shreg_d   = head;
               par_bit_d = (^head) ^ odd_sel;
               state_d   = START;
               tx_d      = 1'b0;
            end
         end
         START: begin
            if (div_last) begin
               state_d = DATA;
               tx_d    = shreg[0];
            end
         end
         DATA: begin
            if (div_last) begin
               if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  bit_cnt_d = '0;
                  if (PARITY != 0) begin
                     state_d = PAR;
                     tx_d    = par_bit;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt + BIT_W'(1);
                  shreg_d   = shreg >> 1;
                  tx_d      = shreg[1];
               end
            end
         end
         PAR: begin
            if (div_last) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            // bit_cnt is reused as the stop-bit index
            if (div_last) begin
               if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if (fifo_nonempty) begin
                     pop       = 1'b1;
                     shreg_d   = head;
                     par_bit_d = (^head) ^ odd_sel;
                     state_d   = START;
                     tx_d      = 1'b0;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule
